// File: rtl/la_cellbist_pkg.sv
// la_cellbist_pkg: shared state encoding and widths for the cell self-test harness
package la_cellbist_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam int CODE_W = 4;
  localparam int NCODES = 16;
  localparam int CNT_W = 5;
  localparam int SETTLE_W = 8;
endpackage

// File: rtl/la_settle_timer.sv
// la_settle_timer: loadable down-counter that flags expiry when it reaches zero
module la_settle_timer
  import la_cellbist_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                expired
);
  logic [SETTLE_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign expired = cnt == '0;
endmodule

// File: rtl/la_cellbist4.sv
// la_cellbist4: sweeps a 4-input cell through all 16 codes and checks z against a truth table
module la_cellbist4
  import la_cellbist_pkg::*;
#(
  parameter string             PROP   = "DEFAULT",
  parameter logic [NCODES-1:0] TRUTH  = 16'hE000,
  parameter int                SETTLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              a0,
  output logic              a1,
  output logic              b0,
  output logic              c0,
  input  logic              z,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [CODE_W-1:0] fail_idx
);
  state_t state, state_n;
  logic [CODE_W-1:0] code;
  logic load, expired, go, last, miss;
  assign go = start && (state == IDLE || state == DONE);
  assign last = code == CODE_W'(NCODES - 1);
  assign miss = z != TRUTH[code];
  assign busy = state == DRIVE || state == SAMPLE;
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  assign {c0, b0, a1, a0} = busy ? code : '0;
  la_settle_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (SETTLE_W'(SETTLE - 1)),
    .expired  (expired)
  );
  always_comb begin
    state_n = go ? DRIVE
            : state == DRIVE && expired ? SAMPLE
            : state == SAMPLE ? (last ? DONE : DRIVE)
            : state;
    load = go || (state == SAMPLE && !last);
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset || go) begin
      code <= '0;
      err_count <= '0;
      fail_idx <= '0;
    end else if (state == SAMPLE) begin
      if (miss) begin
        err_count <= err_count + 1'b1;
        if (err_count == '0) fail_idx <= code;
      end
      if (!last) code <= code + 1'b1;
    end
  end
endmodule

// File: tb/tb_la_cellbist4.sv
// tb_la_cellbist4: checks two harness instances (SETTLE 1 and 4) against a timing-level model
module tb_la_cellbist4;
  localparam logic [15:0] TRUTH = 16'hE000;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] rst, start, z;
  logic a0_1, a1_1, b0_1, c0_1, busy1, done1, pass1;
  logic a0_4, a1_4, b0_4, c0_4, busy4, done4, pass4;
  logic [4:0] err1, err4;
  logic [3:0] fidx1, fidx4;
  logic [3:0] stim [2];
  logic [1:0] busy, done, pass;
  logic [4:0] err [2];
  logic [3:0] fidx [2];
  int mode [2];
  int dly [2];
  logic [3:0] pipe [2][8];
  bit chk_en = 1'b0;
  int checks = 0;
  int errors = 0;
  bit run [2];
  bit mdone [2];
  int t [2];
  int merr [2];
  int mfail [2];
  la_cellbist4 #(.SETTLE(1)) u_dut1 (
    .clk(clk), .reset(rst[0]), .start(start[0]),
    .a0(a0_1), .a1(a1_1), .b0(b0_1), .c0(c0_1), .z(z[0]),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_idx(fidx1)
  );
  la_cellbist4 #(.SETTLE(4)) u_dut4 (
    .clk(clk), .reset(rst[1]), .start(start[1]),
    .a0(a0_4), .a1(a1_4), .b0(b0_4), .c0(c0_4), .z(z[1]),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4), .fail_idx(fidx4)
  );
  assign stim[0] = {c0_1, b0_1, a1_1, a0_1};
  assign stim[1] = {c0_4, b0_4, a1_4, a0_4};
  assign busy = {busy4, busy1};
  assign done = {done4, done1};
  assign pass = {pass4, pass1};
  assign err[0] = err1;
  assign err[1] = err4;
  assign fidx[0] = fidx1;
  assign fidx[1] = fidx4;
  function automatic int sv(int i);
    return i == 0 ? 1 : 4;
  endfunction
  function automatic logic oa211(logic [3:0] c);
    return (c[0] | c[1]) & c[2] & c[3];
  endfunction
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      pipe[i][0] <= stim[i];
      for (int k = 1; k < 8; k++) pipe[i][k] <= pipe[i][k-1];
    end
  always_comb begin
    z = '0;
    for (int i = 0; i < 2; i++) begin
      if (mode[i] == 1) z[i] = 1'b0;
      else if (mode[i] == 2) z[i] = 1'b1;
      else if (dly[i] == 0) z[i] = oa211(stim[i]);
      else z[i] = oa211(pipe[i][dly[i]-1]);
    end
  end
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        run[i] = 0; mdone[i] = 0; merr[i] = 0; mfail[i] = 0; t[i] = 0;
      end else if (start[i] && !run[i]) begin
        run[i] = 1; mdone[i] = 0; merr[i] = 0; mfail[i] = 0; t[i] = 0;
      end else if (run[i]) begin
        t[i]++;
        if (t[i] % (sv(i) + 1) == 0) begin
          int k;
          k = t[i] / (sv(i) + 1) - 1;
          if (z[i] != TRUTH[k]) begin
            if (merr[i] == 0) mfail[i] = k;
            merr[i]++;
          end
          if (k == 15) begin run[i] = 0; mdone[i] = 1; end
        end
      end
    end
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  always @(negedge clk)
    if (chk_en)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d", i), busy[i], run[i]);
        chk($sformatf("stim%0d", i), stim[i], run[i] ? t[i] / (sv(i) + 1) : 0);
        chk($sformatf("done%0d", i), done[i], mdone[i]);
        chk($sformatf("pass%0d", i), pass[i], mdone[i] && merr[i] == 0);
        chk($sformatf("err%0d", i), err[i], merr[i]);
        if (merr[i] != 0) chk($sformatf("fidx%0d", i), fidx[i], mfail[i]);
      end
  task automatic sweep(input int i, output int cyc, output int nb);
    @(negedge clk) start[i] = 1'b1;
    cyc = 0;
    nb = 0;
    while (1) begin
      @(negedge clk) start[i] = 1'b0;
      cyc++;
      if (done[i]) break;
      if (busy[i]) nb++;
      if (cyc > 200) begin
        checks++;
        errors++;
        $display("FAIL timeout%0d: got %0d cycles expected done", i, cyc);
        break;
      end
    end
  endtask
  initial begin
    int cyc, nb;
    rst = 2'b11;
    start = 2'b00;
    mode = '{0, 0};
    dly = '{0, 0};
    repeat (3) @(negedge clk);
    rst = 2'b00;
    chk_en = 1'b1;
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_err", err[0], 0);
    sweep(0, cyc, nb);
    chk("ideal_cyc", cyc, 33);
    chk("ideal_busy_cycles", nb, 32);
    chk("ideal_pass", pass[0], 1);
    chk("ideal_err", err[0], 0);
    mode[0] = 1;
    sweep(0, cyc, nb);
    chk("sa0_err", err[0], 3);
    chk("sa0_fidx", fidx[0], 13);
    chk("sa0_pass", pass[0], 0);
    chk("sa0_done", done[0], 1);
    chk("sa0_model_err", merr[0], 3);
    mode[0] = 2;
    sweep(0, cyc, nb);
    chk("sa1_err", err[0], 13);
    chk("sa1_fidx", fidx[0], 0);
    chk("sa1_model_fidx", mfail[0], 0);
    dly[1] = 3;
    sweep(1, cyc, nb);
    chk("d3_cyc", cyc, 81);
    chk("d3_pass", pass[1], 1);
    dly[1] = 5;
    sweep(1, cyc, nb);
    chk("d5_err_nonzero", err[1] != 0, 1);
    chk("d5_pass", pass[1], 0);
    mode[0] = 0;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid_code7", stim[0], 7);
    rst[0] = 1'b1;
    @(negedge clk) rst[0] = 1'b0;
    chk("mid_rst_stim", stim[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_done", done[0], 0);
    chk("mid_rst_pass", pass[0], 0);
    chk("mid_rst_err", err[0], 0);
    sweep(0, cyc, nb);
    chk("post_rst_cyc", cyc, 33);
    chk("post_rst_pass", pass[0], 1);
    mode[0] = 1;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_start_pre", stim[0], 2);
    start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    chk("busy_start_code", stim[0], 2);
    chk("busy_start_busy", busy[0], 1);
    for (int n = 0; n < 100 && !done[0]; n++) @(negedge clk);
    chk("restart_pre_done", done[0], 1);
    chk("restart_pre_err", err[0], 3);
    start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    chk("restart_done", done[0], 0);
    chk("restart_err", err[0], 0);
    chk("restart_code", stim[0], 0);
    chk("restart_busy", busy[0], 1);
    for (int n = 0; n < 100 && !done[0]; n++) @(negedge clk);
    chk("restart_final_err", err[0], 3);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
